approx_adder_err_monitor: RTL and testbench
===========================================

// Module: approx_adder_err_monitor
// PURPOSE
//  Downstream consumer of the 6-bit approximate adder. Each sample carries the
//  adder's operands and its approximate 8-bit sum. The block recomputes the
//  exact sum and measures the error magnitude. It accumulates error statistics
//  over a window of WINDOW samples, then presents one report through a
//  valid/ready handshake. Used to score BMF-approximated adder netlists in
//  simulation and on FPGA.
// PARAMETERS
//  OP_W    6    operand width; exact sum = a+b+cin, OP_W+1 bits
//  SUM_W   8    approximate-sum width; exact sum is zero-extended to SUM_W
//  WINDOW  256  samples per report; must be >= 1
//  ACC_W   24   width of the sum_abs_err and sum_sq_err accumulators
//  CNT_W   $clog2(WINDOW+1)  width of the sample and error counters
// PORTS
//  clk            in   1      clock; all logic on the rising edge
//  rst            in   1      synchronous reset, active-high
//  start          in   1      1-cycle pulse; opens a window (honoured only in IDLE)
//  in_valid       in   1      sample valid
//  in_ready       out  1      sample accepted when in_valid & in_ready
//  in_a           in   OP_W   operand A
//  in_b           in   OP_W   operand B
//  in_cin         in   1      carry-in
//  in_approx      in   SUM_W  approximate sum (bit0 = LSB)
//  report_valid   out  1      report fields valid and held stable
//  report_ready   in   1      report consumed when report_valid & report_ready
//  sample_count   out  CNT_W  samples accepted in this window
//  err_count      out  CNT_W  samples with abs_err != 0
//  max_abs_err    out  SUM_W  largest abs_err in this window
//  sum_abs_err    out  ACC_W  sum of abs_err, saturating
//  sat            out  1      sticky: an accumulator saturated in this window
// BEHAVIOUR
//  Reset: state=IDLE. Every output is 0; in_ready=0; report_valid=0.
//  FSM: IDLE -start-> RUN (clears all accumulators, counters and sat)
//       RUN  -WINDOW-th accept-> DRAIN -pipe empty-> REPORT
//       REPORT -report_valid&report_ready-> IDLE
//  in_ready=1 only in RUN. Samples with in_valid in any other state are dropped.
//  start outside IDLE is ignored. A start in the cycle the report is consumed
//  is also ignored.
//  Pipeline, 2 stages:
//   S1: exact = a+b+cin (zero-extended); abs_err = |approx-exact|, computed at
//       SUM_W+1 bits and then taken as SUM_W bits.
//   S2: updates the accumulators.
//  An accepted sample shows in the statistics 2 cycles after acceptance.
//  DRAIN lasts exactly 2 cycles.
//  Accumulators saturate at all-ones and never wrap. Any saturation event sets
//  sat, which stays set until the next start or rst.
//  Report fields are held stable from report_valid rising until the handshake.
//  They remain readable in IDLE until the next start clears them.
//  rst mid-operation: the next cycle is IDLE with all state cleared. In-flight
//  samples are discarded.
// CONFIGURATION
//  SQ_ERR_EN defined: adds output port sum_sq_err [ACC_W], the saturating sum of
//   abs_err*abs_err. It follows the same S2 timing, clear rules and sat
//   contribution as sum_abs_err.
//  SQ_ERR_EN undefined: the port and its multiplier are absent. All other
//   behaviour is identical.
// TESTING
//  1 WINDOW=4: start; 4 samples a=5,b=3,cin=0,approx=8
//    -> report sample_count=4, err_count=0, max_abs_err=0, sum_abs_err=0, sat=0.
//  2 WINDOW=2: samples (63,63,1,approx=120) and (63,63,1,approx=130)
//    -> err_count=2, max_abs_err=7, sum_abs_err=10.
//  3 Hold report_ready=0 for 10 cycles in REPORT with in_valid=1
//    -> report_valid stays 1, fields unchanged, in_ready=0, no sample counted.
//  4 Assert rst for 1 cycle after 2 accepts in RUN
//    -> next cycle IDLE, all outputs 0; a following start opens a clean window.
//  5 ACC_W=8, WINDOW=2: two samples with approx=255, exact=0
//    -> sum_abs_err=255, sat=1, max_abs_err=255.
//  6 SQ_ERR_EN, WINDOW=2: errors 7 and 3 (as in 2)
//    -> sum_sq_err=58; start, report, and in_valid in the same cycle -> start ignored.

Source files
------------

// File: rtl/approx_adder_err_monitor.sv
// Error monitor for an approximate adder: recomputes the exact sum and gathers per-window error
// statistics. Define SQ_ERR_EN to add the saturating sum-of-squared-error output sum_sq_err.
module approx_adder_err_monitor #(
  parameter int unsigned OP_W   = 6,
  parameter int unsigned SUM_W  = 8,
  parameter int unsigned WINDOW = 256,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_cin,
  input  logic [SUM_W-1:0] in_approx,
  output logic             report_valid,
  input  logic             report_ready,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [SUM_W-1:0] max_abs_err,
  output logic [ACC_W-1:0] sum_abs_err,
`ifdef SQ_ERR_EN
  output logic [ACC_W-1:0] sum_sq_err,
`endif
  output logic             sat
);

  localparam int unsigned DW   = SUM_W + 1;
  localparam int unsigned AW   = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
  localparam int unsigned SQ_W = 2 * SUM_W;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StReport} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic             drain_q, drain_d;
  logic             clear;
  logic             accept;

  assign in_ready     = (state_q == StRun);
  assign report_valid = (state_q == StReport);
  assign accept       = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    drain_d  = drain_q;
    clear    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          in_cnt_d = '0;
          clear    = 1'b1;
        end
      end
      StRun: begin
        if (accept) begin
          in_cnt_d = in_cnt_q + CNT_W'(1);
          if (in_cnt_q == CNT_W'(WINDOW - 1)) begin
            state_d = StDrain;
            drain_d = 1'b0;
          end
        end
      end
      StDrain: begin
        // Two cycles flush S1 and S2 so the report sees the last sample.
        drain_d = 1'b1;
        if (drain_q) state_d = StReport;
      end
      StReport: begin
        if (report_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Stage 1: exact sum and absolute error.
  logic [DW-1:0]    exact;
  logic [DW-1:0]    diff;
  logic [DW-1:0]    abs_wide;
  logic             s1_valid_q;
  logic [SUM_W-1:0] s1_err_q;

  always_comb begin
    exact    = DW'(in_a) + DW'(in_b) + DW'(in_cin);
    diff     = {1'b0, in_approx} - exact;
    abs_wide = diff[DW-1] ? (~diff + DW'(1)) : diff;
  end

  // Stage 2: accumulator next-state.
  logic [AW-1:0]    abs_sum;
  logic             abs_ovf;
  logic [CNT_W-1:0] sample_count_d, err_count_d;
  logic [SUM_W-1:0] max_abs_err_d;
  logic [ACC_W-1:0] sum_abs_err_d;
  logic             sat_d;

`ifdef SQ_ERR_EN
  localparam int unsigned QW = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;
  logic [SQ_W-1:0]  sq;
  logic [QW-1:0]    sq_sum;
  logic             sq_ovf;
  logic [ACC_W-1:0] sum_sq_err_d;

  always_comb begin
    sq           = SQ_W'(s1_err_q) * SQ_W'(s1_err_q);
    sq_sum       = QW'(sum_sq_err) + QW'(sq);
    sq_ovf       = |sq_sum[QW-1:ACC_W];
    sum_sq_err_d = sq_ovf ? '1 : sq_sum[ACC_W-1:0];
  end
`endif

  always_comb begin
    abs_sum        = AW'(sum_abs_err) + AW'(s1_err_q);
    abs_ovf        = |abs_sum[AW-1:ACC_W];
    sum_abs_err_d  = abs_ovf ? '1 : abs_sum[ACC_W-1:0];
    sample_count_d = sample_count + CNT_W'(1);
    err_count_d    = (s1_err_q != '0) ? err_count + CNT_W'(1) : err_count;
    max_abs_err_d  = (s1_err_q > max_abs_err) ? s1_err_q : max_abs_err;
    sat_d          = sat | abs_ovf;
`ifdef SQ_ERR_EN
    sat_d          = sat_d | sq_ovf;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      in_cnt_q     <= '0;
      drain_q      <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_err_q     <= '0;
      sample_count <= '0;
      err_count    <= '0;
      max_abs_err  <= '0;
      sum_abs_err  <= '0;
`ifdef SQ_ERR_EN
      sum_sq_err   <= '0;
`endif
      sat          <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      drain_q    <= drain_d;
      s1_valid_q <= accept;
      s1_err_q   <= abs_wide[SUM_W-1:0];
      if (clear) begin
        sample_count <= '0;
        err_count    <= '0;
        max_abs_err  <= '0;
        sum_abs_err  <= '0;
`ifdef SQ_ERR_EN
        sum_sq_err   <= '0;
`endif
        sat          <= 1'b0;
      end else if (s1_valid_q) begin
        sample_count <= sample_count_d;
        err_count    <= err_count_d;
        max_abs_err  <= max_abs_err_d;
        sum_abs_err  <= sum_abs_err_d;
`ifdef SQ_ERR_EN
        sum_sq_err   <= sum_sq_err_d;
`endif
        sat          <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Directed bench for approx_adder_err_monitor with a 2-sample window and 8-bit accumulators.
module tb_approx_adder_err_monitor;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned SUM_W  = 8;
  localparam int unsigned WINDOW = 2;
  localparam int unsigned ACC_W  = 8;
  localparam int unsigned CNT_W  = $clog2(WINDOW + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OP_W-1:0]  in_a = '0;
  logic [OP_W-1:0]  in_b = '0;
  logic             in_cin = 1'b0;
  logic [SUM_W-1:0] in_approx = '0;
  logic             report_valid;
  logic             report_ready = 1'b0;
  logic [CNT_W-1:0] sample_count;
  logic [CNT_W-1:0] err_count;
  logic [SUM_W-1:0] max_abs_err;
  logic [ACC_W-1:0] sum_abs_err;
`ifdef SQ_ERR_EN
  logic [ACC_W-1:0] sum_sq_err;
`endif
  logic             sat;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  approx_adder_err_monitor #(
    .OP_W  (OP_W),
    .SUM_W (SUM_W),
    .WINDOW(WINDOW),
    .ACC_W (ACC_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_cin      (in_cin),
    .in_approx   (in_approx),
    .report_valid(report_valid),
    .report_ready(report_ready),
    .sample_count(sample_count),
    .err_count   (err_count),
    .max_abs_err (max_abs_err),
    .sum_abs_err (sum_abs_err),
`ifdef SQ_ERR_EN
    .sum_sq_err  (sum_sq_err),
`endif
    .sat         (sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int a, input int b, input int cin, input int approx);
    in_valid  = 1'b1;
    in_a      = OP_W'(a);
    in_b      = OP_W'(b);
    in_cin    = cin[0];
    in_approx = SUM_W'(approx);
  endtask

  task automatic check_stats(input string tag, input int cnt, input int errs, input int mx,
                             input int sum, input int s);
    check({tag, "_count"}, 32'(sample_count), cnt);
    check({tag, "_errs"}, 32'(err_count), errs);
    check({tag, "_max"}, 32'(max_abs_err), mx);
    check({tag, "_sum"}, 32'(sum_abs_err), sum);
    check({tag, "_sat"}, 32'(sat), s);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_report_valid", 32'(report_valid), 0);
    check_stats("rst", 0, 0, 0, 0, 0);
`ifdef SQ_ERR_EN
    check("rst_sq", 32'(sum_sq_err), 0);
`endif

    // Exact samples: no error.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_in_ready", 32'(in_ready), 1);
    drive(5, 3, 0, 8);
    tick();
    tick();
    check("drain_in_ready", 32'(in_ready), 0);
    tick();
    check("drain_len", 32'(report_valid), 0);
    tick();
    check("report_valid", 32'(report_valid), 1);
    check_stats("exact", 2, 0, 0, 0, 0);

    // Held report with samples offered: nothing changes.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_valid", 32'(report_valid), 1);
      check("hold_in_ready", 32'(in_ready), 0);
      check("hold_count", 32'(sample_count), 2);
    end
    report_ready = 1'b1;
    tick();
    report_ready = 1'b0;
    in_valid = 1'b0;
    check("consumed_valid", 32'(report_valid), 0);
    check("idle_readable", 32'(sample_count), 2);

    // Errors 7 and 3.
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(63, 63, 1, 120);
    tick();
    drive(63, 63, 1, 130);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("err_report_valid", 32'(report_valid), 1);
    check_stats("err", 2, 2, 7, 10, 0);
`ifdef SQ_ERR_EN
    check("err_sq", 32'(sum_sq_err), 58);
`endif

    // start coinciding with the report handshake is ignored.
    start = 1'b1;
    report_ready = 1'b1;
    in_valid = 1'b1;
    tick();
    start = 1'b0;
    report_ready = 1'b0;
    in_valid = 1'b0;
    check("collide_valid", 32'(report_valid), 0);
    check("collide_in_ready", 32'(in_ready), 0);
    tick();
    check("collide_still_idle", 32'(in_ready), 0);
    check("collide_errs_kept", 32'(err_count), 2);

    // Start clears, one sample lands, then reset mid-window.
    start = 1'b1;
    tick();
    start = 1'b0;
    check_stats("clear", 0, 0, 0, 0, 0);
    drive(0, 0, 0, 20);
    tick();
    in_valid = 1'b0;
    tick();
    check("pipe_latency_sum", 32'(sum_abs_err), 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", 32'(in_ready), 0);
    check("mid_rst_valid", 32'(report_valid), 0);
    check_stats("mid_rst", 0, 0, 0, 0, 0);
    tick();
    check("mid_rst_idle", 32'(in_ready), 0);

    // Clean window after reset.
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(1, 2, 1, 4);
    tick();
    drive(0, 0, 0, 3);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("clean_valid", 32'(report_valid), 1);
    check_stats("clean", 2, 1, 3, 3, 0);
`ifdef SQ_ERR_EN
    check("clean_sq", 32'(sum_sq_err), 9);
`endif
    report_ready = 1'b1;
    tick();
    report_ready = 1'b0;

    // Saturation of the 8-bit accumulators.
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(0, 0, 0, 255);
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("sat_valid", 32'(report_valid), 1);
    check_stats("sat", 2, 2, 255, 255, 1);
`ifdef SQ_ERR_EN
    check("sat_sq", 32'(sum_sq_err), 255);
`endif
    report_ready = 1'b1;
    tick();
    report_ready = 1'b0;
    check("sat_sticky_idle", 32'(sat), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("sat_cleared", 32'(sat), 0);
    check("sum_cleared", 32'(sum_abs_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
